// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================
// cnn_pkg - shared pixel width, pool FSM encoding, unsigned max
// Rev 1.0
// ============================================================
package cnn_pkg;

  localparam int POOL_DATA_WIDTH = 16;
  localparam int MAX_U_W         = 32;

  typedef enum logic [1:0] {
    POOL_IDLE = 2'd0,
    POOL_RUN  = 2'd1,
    POOL_DONE = 2'd2
  } pool_state_t;

  // Operands are zero-extended by the caller; ties may return either side.
  function automatic logic [MAX_U_W-1:0] max_u(input logic [MAX_U_W-1:0] a,
                                               input logic [MAX_U_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_line_buf.sv
`default_nettype none
// ============================================================
// pool_line_buf - one row of horizontal maxima, sync write / comb read
// Rev 1.0
// ============================================================
module pool_line_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 31,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk1,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // No reset: every entry is written on an even row before an odd row reads it.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk1) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================
// max_pool_2x2 - streaming 2x2 / stride-2 max-pool behind CONV
// Rev 1.0
// ============================================================
module max_pool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int IFM_SIZE   = 62,
  parameter int CHANNELS   = 8
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  start_pool,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  end_pool
);

  localparam int OFM_SIZE = IFM_SIZE / 2;
  localparam int CNT_W    = $clog2(IFM_SIZE);
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ADDR_W   = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IFM_SIZE - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam bit               ODD_IFM  = (IFM_SIZE % 2) != 0;

  pool_state_t state, next_state;

  logic [CNT_W-1:0]      col, row;
  logic [CH_W-1:0]       ch;
  logic [DATA_WIDTH-1:0] hreg;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] line_rd;
  logic [DATA_WIDTH-1:0] pool_max;
  logic [ADDR_W-1:0]     line_addr;
  logic                  accept;
  logic                  last_pix;
  logic                  line_we;

  // A start_pool cycle owns the pixel on the bus: it is dropped, not counted.
  assign accept    = (state == POOL_RUN) && in_valid && !start_pool;
  assign last_pix  = (col == LAST_POS) && (row == LAST_POS) && (ch == LAST_CH);
  assign hmax      = DATA_WIDTH'(max_u(MAX_U_W'(hreg), MAX_U_W'(in_data)));
  assign pool_max  = DATA_WIDTH'(max_u(MAX_U_W'(hmax), MAX_U_W'(line_rd)));
  assign line_addr = ADDR_W'(col >> 1);
  assign line_we   = accept && col[0] && !row[0];

  pool_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OFM_SIZE),
    .ADDR_W     (ADDR_W)
  ) u_line_buf (
    .clk1  (clk1),
    .we    (line_we),
    .addr  (line_addr),
    .wdata (hmax),
    .rdata (line_rd)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state <= POOL_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      POOL_IDLE: if (start_pool) next_state = POOL_RUN;
      POOL_RUN:  if (accept && last_pix) next_state = POOL_DONE;
      POOL_DONE: next_state = start_pool ? POOL_RUN : POOL_IDLE;
      default:   next_state = POOL_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      POOL_RUN:  busy = 1'b1;
      POOL_DONE: busy = !end_pool;
      default:   busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      ch        <= '0;
      hreg      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      end_pool  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // Even size: the last pixel closes a window, so end_pool waits one more cycle.
      end_pool  <= ODD_IFM ? (accept && last_pix) : (state == POOL_DONE);
      if (start_pool) begin
        col <= '0;
        row <= '0;
        ch  <= '0;
      end else if (accept) begin
        if (!col[0]) begin
          hreg <= in_data;
        end else if (row[0]) begin
          out_valid <= 1'b1;
          out_data  <= pool_max;
        end
        if (col == LAST_POS) begin
          col <= '0;
          if (row == LAST_POS) begin
            row <= '0;
            ch  <= (ch == LAST_CH) ? '0 : ch + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================
// tb_max_pool_2x2 - directed checks on 4x4x1, 5x5x2 and 62x62x8 pools
// Rev 1.0
// ============================================================
module tb_max_pool_2x2;

  localparam int DW = 16;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;
  logic rst;

  logic a_start, a_in_valid, a_out_valid, a_busy, a_end_pool;
  logic [DW-1:0] a_in_data, a_out_data;
  logic b_start, b_in_valid, b_out_valid, b_busy, b_end_pool;
  logic [DW-1:0] b_in_data, b_out_data;
  logic c_start, c_in_valid, c_out_valid, c_busy, c_end_pool;
  logic [DW-1:0] c_in_data, c_out_data;

  max_pool_2x2 #(.DATA_WIDTH(DW), .IFM_SIZE(4), .CHANNELS(1)) dut_a (
    .clk1(clk1), .rst(rst), .start_pool(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_data(a_out_data), .busy(a_busy), .end_pool(a_end_pool));

  max_pool_2x2 #(.DATA_WIDTH(DW), .IFM_SIZE(5), .CHANNELS(2)) dut_b (
    .clk1(clk1), .rst(rst), .start_pool(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_data(b_out_data), .busy(b_busy), .end_pool(b_end_pool));

  max_pool_2x2 #(.DATA_WIDTH(DW), .IFM_SIZE(62), .CHANNELS(8)) dut_c (
    .clk1(clk1), .rst(rst), .start_pool(c_start), .in_valid(c_in_valid), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_data(c_out_data), .busy(c_busy), .end_pool(c_end_pool));

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int a_dq[$], a_sq[$], a_eq[$];
  int b_dq[$], b_sq[$], b_eq[$];
  int c_dq[$], c_sq[$], c_eq[$];

  // Outputs are sampled on the falling edge and stamped with the cycle number.
  always @(negedge clk1) begin
    ncyc = ncyc + 1;
    if (a_out_valid) begin a_dq.push_back(int'(a_out_data)); a_sq.push_back(ncyc); end
    if (a_end_pool)  a_eq.push_back(ncyc);
    if (b_out_valid) begin b_dq.push_back(int'(b_out_data)); b_sq.push_back(ncyc); end
    if (b_end_pool)  b_eq.push_back(ncyc);
    if (c_out_valid) begin c_dq.push_back(int'(c_out_data)); c_sq.push_back(ncyc); end
    if (c_end_pool)  c_eq.push_back(ncyc);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle on the chosen DUT; stamp is the cycle whose falling edge
  // precedes the sampling edge, so a registered response shows at stamp+1.
  task automatic drive(input int sel, input logic s, input logic v, input int d, output int stamp);
    @(negedge clk1);
    #1;
    stamp = ncyc;
    case (sel)
      0: begin a_start = s; a_in_valid = v; a_in_data = DW'(d); end
      1: begin b_start = s; b_in_valid = v; b_in_data = DW'(d); end
      default: begin c_start = s; c_in_valid = v; c_in_data = DW'(d); end
    endcase
  endtask

  task automatic idle(input int sel, input int n);
    int st;
    for (int i = 0; i < n; i++) drive(sel, 1'b0, 1'b0, 0, st);
  endtask

  task automatic clear_q();
    a_dq.delete(); a_sq.delete(); a_eq.delete();
    b_dq.delete(); b_sq.delete(); b_eq.delete();
    c_dq.delete(); c_sq.delete(); c_eq.delete();
  endtask

  function automatic int pix(int chn, int r, int c);
    return (r * 37 + c * 101 + chn * 59 + ((r * c) % 11) * 257) % 65536;
  endfunction

  function automatic int max4(int p, int q, int r, int s);
    int m;
    m = p;
    if (q > m) m = q;
    if (r > m) m = r;
    if (s > m) m = s;
    return m;
  endfunction

  initial begin
    int st;
    int stamps[16];
    int last_st;
    int exp_a[4];
    int exp_b[4];
    int exp_c[$];

    exp_a = '{5, 7, 13, 15};
    exp_b = '{6, 8, 16, 18};
    a_start = 0; a_in_valid = 0; a_in_data = '0;
    b_start = 0; b_in_valid = 0; b_in_data = '0;
    c_start = 0; c_in_valid = 0; c_in_data = '0;
    rst = 1'b1;
    #1;
    check_val("reset_out_valid", 32'(a_out_valid), 32'd0);
    check_val("reset_out_data",  32'(a_out_data),  32'd0);
    check_val("reset_busy",      32'(a_busy),      32'd0);
    check_val("reset_end_pool",  32'(a_end_pool),  32'd0);
    @(negedge clk1); #1 rst = 1'b0;
    idle(0, 2);

    // 4x4 ramp, back to back
    clear_q();
    drive(0, 1'b1, 1'b0, 0, st);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b0, 1'b1, i, st);
      stamps[i] = st;
      if (i == 8) check_val("s1_busy_run", 32'(a_busy), 32'd1);
    end
    idle(0, 4);
    check_val("s1_count", 32'(a_dq.size()), 32'd4);
    for (int j = 0; j < 4 && j < a_dq.size(); j++) begin
      check_val("s1_data", 32'(a_dq[j]), 32'(exp_a[j]));
      check_val("s1_latency", 32'(a_sq[j]), 32'(stamps[exp_a[j]] + 1));
    end
    check_val("s1_end_count", 32'(a_eq.size()), 32'd1);
    if (a_eq.size() > 0) check_val("s1_end_time", 32'(a_eq[0]), 32'(stamps[15] + 2));
    check_val("s1_busy_after", 32'(a_busy), 32'd0);

    // same ramp with random gaps
    clear_q();
    drive(0, 1'b1, 1'b0, 0, st);
    for (int i = 0; i < 16; i++) begin
      idle(0, $urandom_range(0, 3));
      drive(0, 1'b0, 1'b1, i, st);
      stamps[i] = st;
    end
    idle(0, 4);
    check_val("s3_count", 32'(a_dq.size()), 32'd4);
    for (int j = 0; j < 4 && j < a_dq.size(); j++) begin
      check_val("s3_data", 32'(a_dq[j]), 32'(exp_a[j]));
      check_val("s3_latency", 32'(a_sq[j]), 32'(stamps[exp_a[j]] + 1));
    end
    check_val("s3_end_count", 32'(a_eq.size()), 32'd1);

    // abort after 7 large pixels; restart carries a pixel that must be dropped
    drive(0, 1'b1, 1'b0, 0, st);
    for (int i = 0; i < 7; i++) drive(0, 1'b0, 1'b1, 100 + i, st);
    drive(0, 1'b1, 1'b1, 200, st);
    clear_q();
    for (int i = 0; i < 16; i++) drive(0, 1'b0, 1'b1, i, st);
    idle(0, 4);
    check_val("s5_count", 32'(a_dq.size()), 32'd4);
    for (int j = 0; j < 4 && j < a_dq.size(); j++) check_val("s5_data", 32'(a_dq[j]), 32'(exp_a[j]));
    check_val("s5_end_count", 32'(a_eq.size()), 32'd1);

    // asynchronous reset mid-frame while out_valid is high
    drive(0, 1'b1, 1'b0, 0, st);
    for (int i = 0; i < 6; i++) drive(0, 1'b0, 1'b1, i, st);
    @(negedge clk1);
    #1;
    a_in_valid = 1'b0;
    check_val("s6_pre_out_valid", 32'(a_out_valid), 32'd1);
    check_val("s6_pre_busy", 32'(a_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("s6_rst_out_valid", 32'(a_out_valid), 32'd0);
    check_val("s6_rst_busy", 32'(a_busy), 32'd0);
    @(negedge clk1); #1 rst = 1'b0;
    clear_q();
    for (int i = 0; i < 16; i++) drive(0, 1'b0, 1'b1, i + 50, st);
    idle(0, 4);
    check_val("s6_no_output", 32'(a_dq.size()), 32'd0);
    check_val("s6_no_end", 32'(a_eq.size()), 32'd0);
    check_val("s6_busy", 32'(a_busy), 32'd0);

    // 5x5, two channels: last row and column dropped
    clear_q();
    drive(1, 1'b1, 1'b0, 0, st);
    for (int chn = 0; chn < 2; chn++)
      for (int i = 0; i < 25; i++) begin
        drive(1, 1'b0, 1'b1, i, st);
        last_st = st;
      end
    idle(1, 4);
    check_val("s4_count", 32'(b_dq.size()), 32'd8);
    for (int j = 0; j < 8 && j < b_dq.size(); j++) check_val("s4_data", 32'(b_dq[j]), 32'(exp_b[j % 4]));
    check_val("s4_end_count", 32'(b_eq.size()), 32'd1);
    if (b_eq.size() > 0) begin
      check_val("s4_end_time", 32'(b_eq[0]), 32'(last_st + 1));
      if (b_sq.size() > 0) check_val("s4_end_alone", 32'(b_eq[0] == b_sq[b_sq.size() - 1]), 32'd0);
    end

    // full-size frame against a software max-pool
    clear_q();
    for (int chn = 0; chn < 8; chn++)
      for (int r = 0; r < 31; r++)
        for (int c = 0; c < 31; c++)
          exp_c.push_back(max4(pix(chn, 2*r, 2*c), pix(chn, 2*r, 2*c+1),
                               pix(chn, 2*r+1, 2*c), pix(chn, 2*r+1, 2*c+1)));
    drive(2, 1'b1, 1'b0, 0, st);
    for (int chn = 0; chn < 8; chn++)
      for (int r = 0; r < 62; r++)
        for (int c = 0; c < 62; c++) begin
          drive(2, 1'b0, 1'b1, pix(chn, r, c), st);
          last_st = st;
        end
    idle(2, 4);
    check_val("s2_count", 32'(c_dq.size()), 32'd7688);
    for (int j = 0; j < exp_c.size() && j < c_dq.size(); j++) check_val("s2_data", 32'(c_dq[j]), 32'(exp_c[j]));
    check_val("s2_end_count", 32'(c_eq.size()), 32'd1);
    if (c_sq.size() > 0) check_val("s2_last_latency", 32'(c_sq[c_sq.size() - 1]), 32'(last_st + 1));
    if (c_eq.size() > 0) check_val("s2_end_time", 32'(c_eq[0]), 32'(last_st + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
